// File: rtl/cordic_pkg.sv
// Shared constants and float field layout for the CORDIC front end, core and back end.
// Pure declarations: no latency, no flow control.
package cordic_pkg;
    localparam int Z_W    = 22;
    localparam int Z_FRAC = 20;

    localparam int FLT_W = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
    localparam logic [EXP_W-1:0] EXP_MIN  = 8'd106;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;
    localparam logic [Z_W-1:0]   ONE_Q    = 22'h100000;

    // Right-shift distance for a normal value is SHIFT_BASE - exponent.
    localparam logic [EXP_W-1:0] SHIFT_BASE = EXP_BIAS + 8'(MAN_W - Z_FRAC);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_ONE,
        CLS_SAT,
        CLS_NAN
    } cls_t;
endpackage

// File: rtl/cordic_align_shift.sv
// Right-shifts a float significand and rounds to nearest, ties away from zero.
// Purely combinational; no flow control.
module cordic_align_shift
    import cordic_pkg::*;
#(
    parameter int OUT_W = 22
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [4:0]       shamt,
    output logic [OUT_W-1:0] mag
);
    // An extra guard bit below the LSB catches the last bit shifted out.
    logic [SIG_W:0] ext;

    assign ext = {sig, 1'b0} >> shamt;
    assign mag = OUT_W'(ext[SIG_W:1]) + OUT_W'(ext[0]);
endmodule

// File: rtl/cordic_float_to_fixed.sv
// Converts an IEEE-754 single angle to Q2.20 fixed point for the CORDIC core; 3 enabled cycles.
// No backpressure: one conversion per enabled cycle, clk_en=0 freezes the whole pipe.
module cordic_float_to_fixed #(
    parameter int Z_W    = cordic_pkg::Z_W,
    parameter int Z_FRAC = cordic_pkg::Z_FRAC
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [31:0]               dataa,
    input  logic                      cos,
    output logic [Z_W-1:0]            z_out,
    output logic                      z_valid,
    output logic                      cos_out,
    output logic                      range_err
);
    import cordic_pkg::*;

    localparam logic [Z_W-1:0] ONE_FIX = Z_W'(1) << Z_FRAC;

    logic [EXP_W-1:0] exp_in;
    logic [MAN_W-1:0] man_in;
    cls_t             cls_d;

    assign exp_in = dataa[30:23];
    assign man_in = dataa[22:0];

    always_comb begin
        cls_d = CLS_ZERO;
        if (exp_in == EXP_MAX)
            cls_d = (man_in != '0) ? CLS_NAN : CLS_SAT;
        else if (exp_in > EXP_BIAS)
            cls_d = CLS_SAT;
        else if (exp_in == EXP_BIAS)
            cls_d = (man_in == '0) ? CLS_ONE : CLS_SAT;
        else if (exp_in >= EXP_MIN)
            cls_d = CLS_NORM;
    end

    // S1: unpack and classify
    logic             v1, sign1, cos1;
    cls_t             cls1;
    logic [EXP_W-1:0] exp1;
    logic [SIG_W-1:0] sig1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            cos1  <= 1'b0;
            cls1  <= CLS_ZERO;
            exp1  <= '0;
            sig1  <= '0;
        end else if (clk_en) begin
            v1 <= start;
            if (start) begin
                sign1 <= dataa[31];
                cos1  <= cos;
                cls1  <= cls_d;
                exp1  <= exp_in;
                sig1  <= {1'b1, man_in};
            end
        end
    end

    // S2: align and round
    logic [4:0]     shamt;
    logic [Z_W-1:0] shift_mag, mag_d;

    assign shamt = 5'(SHIFT_BASE - exp1);

    cordic_align_shift #(.OUT_W(Z_W)) u_align (
        .sig   (sig1),
        .shamt (shamt),
        .mag   (shift_mag)
    );

    always_comb begin
        mag_d = '0;
        case (cls1)
            CLS_NORM:         mag_d = shift_mag;
            CLS_ONE, CLS_SAT: mag_d = ONE_FIX;
            default:          mag_d = '0;
        endcase
    end

    logic           v2, sign2, cos2, err2;
    logic [Z_W-1:0] mag2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            cos2  <= 1'b0;
            err2  <= 1'b0;
            mag2  <= '0;
        end else if (clk_en) begin
            v2 <= v1;
            if (v1) begin
                sign2 <= sign1;
                cos2  <= cos1;
                err2  <= (cls1 == CLS_SAT) || (cls1 == CLS_NAN);
                mag2  <= mag_d;
            end
        end
    end

    // S3: apply sign; outputs only move when a token lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_valid   <= 1'b0;
            z_out     <= '0;
            cos_out   <= 1'b0;
            range_err <= 1'b0;
        end else if (clk_en) begin
            z_valid <= v2;
            if (v2) begin
                z_out     <= sign2 ? -mag2 : mag2;
                cos_out   <= cos2;
                range_err <= err2;
            end
        end
    end
endmodule

// File: tb/tb_cordic_float_to_fixed.sv
// Directed vector bench for cordic_float_to_fixed: table burst plus enable-stall and reset corners.
module tb_cordic_float_to_fixed;
    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        cos;
    logic [21:0] z_out;
    logic        z_valid;
    logic        cos_out;
    logic        range_err;

    int n_cmp = 0;
    int n_bad = 0;

    cordic_float_to_fixed dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .cos       (cos),
        .z_out     (z_out),
        .z_valid   (z_valid),
        .cos_out   (cos_out),
        .range_err (range_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] dataa;
        logic        cos;
        logic [21:0] z;
        logic        err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h3f000000, 1'b1, 22'h080000, 1'b0};
        vecs[1]  = '{32'hbf000000, 1'b0, 22'h380000, 1'b0};
        vecs[2]  = '{32'h3f800000, 1'b1, 22'h100000, 1'b0};
        vecs[3]  = '{32'hbf800000, 1'b0, 22'h300000, 1'b0};
        vecs[4]  = '{32'h40000000, 1'b1, 22'h100000, 1'b1};
        vecs[5]  = '{32'hff800000, 1'b0, 22'h300000, 1'b1};
        vecs[6]  = '{32'h7fc00000, 1'b1, 22'h000000, 1'b1};
        vecs[7]  = '{32'h35000000, 1'b0, 22'h000001, 1'b0};
        vecs[8]  = '{32'h34800000, 1'b1, 22'h000000, 1'b0};
        vecs[9]  = '{32'h00000001, 1'b0, 22'h000000, 1'b0};
        vecs[10] = '{32'h80000000, 1'b1, 22'h000000, 1'b0};
        vecs[11] = '{32'h3e800000, 1'b0, 22'h040000, 1'b0};
        vecs[12] = '{32'hbe800000, 1'b1, 22'h3c0000, 1'b0};
        vecs[13] = '{32'h3f7fffff, 1'b0, 22'h100000, 1'b0};
        vecs[14] = '{32'h3f800001, 1'b1, 22'h100000, 1'b1};
        vecs[15] = '{32'h35c00000, 1'b0, 22'h000002, 1'b0};
        vecs[16] = '{32'h7f800000, 1'b1, 22'h100000, 1'b1};
        vecs[17] = '{32'hffc00000, 1'b0, 22'h000000, 1'b1};

        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        cos     = 1'b0;

        #12;
        chk("rst_z_valid",   z_valid,   0);
        chk("rst_z_out",     z_out,     0);
        chk("rst_range_err", range_err, 0);
        chk("rst_cos_out",   cos_out,   0);
        tick();
        reset_n = 1'b1;

        // Single conversion: latency and one-cycle strobe
        start = 1'b1; dataa = 32'h3f000000; cos = 1'b1;
        tick();
        start = 1'b0; dataa = 32'hdeadbeef; cos = 1'b0;
        chk("lat_edge1_valid", z_valid, 0);
        tick();
        chk("lat_edge2_valid", z_valid, 0);
        tick();
        chk("lat_edge3_valid", z_valid,   1);
        chk("lat_z_out",       z_out,     32'h080000);
        chk("lat_cos_out",     cos_out,   1);
        chk("lat_range_err",   range_err, 0);
        tick();
        chk("lat_edge4_valid", z_valid, 0);
        chk("lat_hold_z_out",  z_out,   32'h080000);

        // Back-to-back burst of the whole table
        for (int i = 0; i < NV + 4; i++) begin
            if (i < NV) begin
                start = 1'b1; dataa = vecs[i].dataa; cos = vecs[i].cos;
            end else begin
                start = 1'b0; dataa = 32'h3f800000; cos = 1'b1;
            end
            tick();
            if (i >= 2 && i - 2 < NV) begin
                chk($sformatf("burst%0d_valid", i - 2), z_valid,   1);
                chk($sformatf("burst%0d_z_out", i - 2), z_out,     vecs[i-2].z);
                chk($sformatf("burst%0d_err",   i - 2), range_err, vecs[i-2].err);
                chk($sformatf("burst%0d_cos",   i - 2), cos_out,   vecs[i-2].cos);
            end else begin
                chk($sformatf("burst_idle%0d_valid", i), z_valid, 0);
            end
        end
        chk("idle_hold_z_out", z_out,     vecs[NV-1].z);
        chk("idle_hold_err",   range_err, vecs[NV-1].err);
        chk("idle_hold_cos",   cos_out,   vecs[NV-1].cos);

        // Enable stall: starts presented while disabled must be ignored
        start = 1'b1; dataa = 32'h3f000000; cos = 1'b1;
        tick();
        clk_en = 1'b0; dataa = 32'h3f800000; cos = 1'b0;
        tick();
        chk("stall_dis1_valid", z_valid, 0);
        tick();
        chk("stall_dis2_valid", z_valid, 0);
        clk_en = 1'b1; start = 1'b0;
        tick();
        chk("stall_en1_valid", z_valid, 0);
        tick();
        chk("stall_out_valid", z_valid, 1);
        chk("stall_z_out",     z_out,   32'h080000);
        chk("stall_cos_out",   cos_out, 1);
        chk("stall_err",       range_err, 0);
        tick();
        chk("stall_after1_valid", z_valid, 0);
        tick();
        chk("stall_after2_valid", z_valid, 0);

        // Reset mid-flight discards tokens and clears outputs at once
        start = 1'b1; dataa = 32'hbf800000; cos = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_z_out",   z_out,   0);
        chk("midrst_valid",   z_valid, 0);
        chk("midrst_cos_out", cos_out, 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("postrst%0d_valid", i), z_valid, 0);
        end
        start = 1'b1; dataa = 32'hbf000000; cos = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("restart_edge2_valid", z_valid, 0);
        tick();
        chk("restart_valid", z_valid,   1);
        chk("restart_z_out", z_out,     32'h380000);
        chk("restart_err",   range_err, 0);
        chk("restart_cos",   cos_out,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
